// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: byte-serial multi-word add/subtract sequencer.
// Time-shares one external combinational 8-bit adder across WORDS byte
// slices, least significant slice first, carrying between slices through a
// single registered carry bit. Subtraction is a + ~b + 1.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered two's-complement
// overflow flag (ovf), valid with done and held like sum.
module serial_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  input  logic                 cin,
  output logic                 ready,
  output logic                 done,
  output logic [8*WORDS-1:0]   sum,
  output logic                 cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic                 ovf,
`endif
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_s,
  input  logic                 add_cout
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WORDS-1:0][7:0]  a_q;
  logic [WORDS-1:0][7:0]  b_q;
  logic [WORDS-1:0][7:0]  sum_q;
  logic                   carry_q;
  logic                   cout_q;
  logic                   done_q;

  // Operand B and slice-0 carry as captured at accept (subtract = add ~b + 1).
  logic [WORDS-1:0][7:0]  b_d;
  logic                   carry_d;
  logic                   run;
  logic [7:0]             slice_a;
  logic [7:0]             slice_b;

  assign b_d     = op_sub ? ~b : b;
  assign carry_d = op_sub | cin;

  assign run     = (state_q == S_RUN);
  assign ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign slice_a = a_q[idx_q];
  assign slice_b = b_q[idx_q];

  // Adder inputs are only driven while slices are being processed; zero otherwise.
  assign add_a   = run ? slice_a : 8'd0;
  assign add_b   = run ? slice_b : 8'd0;
  assign add_cin = run & carry_q;

  assign sum  = sum_q;
  assign cout = cout_q;
  assign done = done_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Carry into the operand MSB recovered from the top bit of the final slice.
  assign msb_cin = slice_a[7] ^ slice_b[7] ^ add_s[7];
  assign ovf     = ovf_q;
`endif

  // Sequencer: accept in IDLE/DONE, one byte slice per RUN cycle, one-cycle DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            state_q <= S_RUN;
          end else begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_q[idx_q] <= add_s;
          carry_q      <= add_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= add_cout;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= add_cout ^ msb_cin;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WORDS=4): models the shared adder, keeps a
// transaction-level model of the requester-visible behaviour, and runs
// directed operations with literal expected results.
module tb_serial_add_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic         op_sub = 1'b0;
  logic         cin    = 1'b0;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic [7:0]   add_s;
  logic         add_cin;
  logic         add_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf      (ovf),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // The shared external adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic         m_ready, m_done, m_cout, m_ovf, m_cin0;
  logic [W-1:0] m_sum, op_a, op_b, p_sum;
  logic         p_cout, p_ovf;
  int           m_cnt;

  // Result of a whole-width operation: {ovf, cout, sum}.
  function automatic logic [W+1:0] full_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sub, input logic ci);
    logic [W-1:0] ye;
    logic [W:0]   t;
    logic         v;
    ye = sub ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
    v  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  // Carry entering byte slice s of the captured operation.
  function automatic logic carry_at(input int s);
    logic [63:0] mk;
    logic [63:0] t;
    mk = (64'd1 << (8 * s)) - 64'd1;
    t  = ({32'd0, op_a} & mk) + ({32'd0, op_b} & mk) + {63'd0, m_cin0};
    return t[8 * s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_cnt   <= 0;
    end else if (m_ready && start) begin
      op_a    <= a;
      op_b    <= op_sub ? ~b : b;
      m_cin0  <= op_sub ? 1'b1 : cin;
      {p_ovf, p_cout, p_sum} <= full_op(a, b, op_sub, cin);
      m_sum   <= '0;
      m_cnt   <= WORDS;
      m_done  <= 1'b0;
      m_ready <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_sum   <= p_sum;
        m_cout  <= p_cout;
        m_ovf   <= p_ovf;
        m_done  <= 1'b1;
        m_ready <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      cmp("ready", ready, m_ready);
      cmp("done", done, m_done);
      if (m_ready) begin
        cmp("sum", sum, m_sum);
        cmp("cout", cout, m_cout);
`ifdef SERIAL_ADD_OVF_EN
        cmp("ovf", ovf, m_ovf);
`endif
        cmp("add_a_idle", add_a, 0);
        cmp("add_b_idle", add_b, 0);
        cmp("add_cin_idle", add_cin, 0);
      end else begin
        cmp("add_a_run", add_a, op_a[8*(WORDS-m_cnt) +: 8]);
        cmp("add_b_run", add_b, op_b[8*(WORDS-m_cnt) +: 8]);
        cmp("add_cin_run", add_cin, carry_at(WORDS - m_cnt));
      end
    end
  end

  // ---------------- directed operations ----------------
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                        input logic tcin, input logic [W-1:0] es, input logic ec,
                        input logic eovf, input string nm, output logic [15:0] tr);
    int n;
    bit seen;
    tr = '0;
    seen = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; op_sub = tsub; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clk);
      if (n <= WORDS) begin
        tr[n-1] = add_cin;
        cmp({nm, "_busy"}, ready, 0);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    cmp({nm, "_done_seen"}, seen, 1);
    cmp({nm, "_latency"}, n, WORDS + 1);
    cmp({nm, "_sum"}, sum, es);
    cmp({nm, "_cout"}, cout, ec);
    cmp({nm, "_model_sum"}, p_sum, es);
`ifdef SERIAL_ADD_OVF_EN
    cmp({nm, "_ovf"}, ovf, eovf);
`else
    if (eovf) cmp({nm, "_model_ovf"}, p_ovf, eovf);
`endif
  endtask

  logic [15:0] trace;
  int          k;
  bit          seen2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_ready", ready, 1);
    cmp("rst_done", done, 0);
    cmp("rst_sum", sum, 0);
    cmp("rst_cout", cout, 0);
    cmp("rst_add_a", add_a, 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // carry ripples out of slice 0 only
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, "add_ff_1", trace);
    cmp("cin_trace", trace[3:0], 4'b0010);

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap_b", trace);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, "add_wrap_cin", trace);
    cmp("cin_trace_all", trace[3:0], 4'b1111);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_borrow", trace);
    run_op(32'h12345678, 32'h02345678, 1'b1, 1'b0, 32'h10000000, 1'b1, 1'b0, "sub_noborrow", trace);

    // start held through RUN, operands changed mid-operation
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'h0000FFFF; b = 32'h00000001;
    seen2 = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        seen2 = 1'b1;
        break;
      end
    end
    cmp("held_first_seen", seen2, 1);
    cmp("held_first_lat", k, WORDS + 1);
    cmp("held_first_sum", sum, 32'h33333333);
    seen2 = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        cmp("held_no_idle", ready, 0);
      end
      if (done) begin
        seen2 = 1'b1;
        break;
      end
    end
    cmp("held_second_seen", seen2, 1);
    cmp("held_second_gap", k, WORDS + 1);
    cmp("held_second_sum", sum, 32'h00010000);
    cmp("held_second_cout", cout, 0);

    // reset pulse while slice 2 is on the adder
    @(negedge clk);
    a = 32'h01020304; b = 32'h10203040; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("pre_rst_add_a", add_a, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    cmp("midrst_sum", sum, 0);
    cmp("midrst_ready", ready, 1);
    cmp("midrst_done", done, 0);
    cmp("midrst_add_a", add_a, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp("postrst_no_done", done, 0);
    end
    run_op(32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0, 1'b0, "post_rst", trace);

    // signed overflow cases
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "ovf_pos", trace);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, "ovf_neg", trace);
    run_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, "ovf_none", trace);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Byte-serial multi-word add/subtract sequencer.
- Time-shares a single external combinational 8-bit adder (8-bit A, B, cin → 8-bit S, cout) across WORDS byte slices, LSB first, with a registered carry chain.
- Sits between a requester with a start/done handshake and the shared 8-bit adder instance. Drives the adder's inputs and samples its outputs.

Parameters:
- WORDS, 4, number of byte slices; operand width = 8*WORDS; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse/level; accepted only when ready=1.
- op_sub  input  1  0: a+b+cin; 1: a-b (cin ignored), sampled at accept.
- a  input  8*WORDS  operand A, sampled at accept.
- b  input  8*WORDS  operand B, sampled at accept.
- cin  input  1  carry-in for add mode, sampled at accept.
- ready  output  1  high in IDLE and DONE; a new start is accepted.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  8*WORDS  result register, held until the next accept.
- cout  output  1  final carry; in sub mode, 1 = no borrow.
- add_a  output  8  to adder A.
- add_b  output  8  to adder B.
- add_cin  output  1  to adder cin.
- add_s  input  8  from adder S.
- add_cout  input  1  from adder cout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, carry=0.
  - a_reg, b_reg, sum, cout, done = 0; ready=1.
  - Adder drive ports = 0.
- States: IDLE, RUN, DONE.
- IDLE, on start=1 at a clock edge:
  - a_reg←a.
  - b_reg←op_sub ? ~b : b.
  - carry←op_sub ? 1 : cin.
  - idx←0; sum←0; go to RUN.
- RUN, combinational drive:
  - add_a=a_reg[8*idx+:8].
  - add_b=b_reg[8*idx+:8].
  - add_cin=carry.
- RUN, each edge:
  - sum[8*idx+:8]←add_s; carry←add_cout.
  - If idx==WORDS-1: cout←add_cout, go to DONE. Otherwise idx←idx+1.
- DONE:
  - done=1 for exactly this one cycle; ready=1.
  - With start=1: accept as from IDLE (back-to-back). Otherwise go to IDLE.
- Latency: accept at edge 0 → done high during the cycle after edge WORDS. Sum is stable from that point.
- Adder drive ports are 0 outside RUN. No combinational path from add_s/add_cout to any output.
- start while in RUN: ignored, no queuing. Operand changes during RUN have no effect.
- sum and cout hold their last values through IDLE until the next accept.
- idx width = clog2(WORDS). idx never exceeds WORDS-1; no wrap past the final slice.
- Reset asserted mid-RUN: immediate return to the reset state. No done pulse; partial sum cleared.
- The carry register is the only inter-slice state; no carry lookahead.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0.
  - At the final slice, ovf←add_cout XOR carry-into-MSB. Carry-into-MSB = (add_a[7]^add_b[7]^add_s[7]) at idx==WORDS-1.
  - ovf indicates two's-complement overflow for the operation.
  - Valid with done; held like sum.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan (WORDS=4, bench models the adder as S,cout = A+B+cin):
- Reset, then a=0x000000FF, b=0x00000001, cin=0, op_sub=0, start 1 cycle:
  - ready=0 for 4 cycles.
  - done pulses in the 5th cycle; sum=0x00000100, cout=0.
  - add_cin observed 0,1,0,0 across slices.
- a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1. Same with cin=1 and b=0 → identical result.
- op_sub=1, a=0x00000005, b=0x00000007 → sum=0xFFFFFFFE, cout=0. With a=0x12345678, b=0x02345678 → sum=0x10000000, cout=1.
- start held high through RUN with different operands:
  - First result is unaffected.
  - start held in DONE launches the next op with no IDLE cycle; second done follows 5 cycles after the first.
- rst_n pulsed low during slice 2:
  - sum=0, done never pulses, ready=1 immediately.
  - A subsequent op completes correctly.
- With SERIAL_ADD_OVF_EN:
  - 0x7FFFFFFF+0x00000001 → ovf=1, sum=0x80000000.
  - 0x80000000−0x00000001 → ovf=1.
  - 0x00000003+0x00000004 → ovf=0.
